// File: rtl/fetch_unit.sv
// Instruction fetch stage. Walks a program counter, reads instruction words
// over a req/ack memory port, buffers them in a small prefetch FIFO and hands
// {op, arg, pc} to the decoder over valid/ready. Redirect flushes and reloads
// the PC. A fetched halt opcode (op == 0) stops fetching until a redirect.
module fetch_unit #(
  parameter int                w          = 8,
  parameter int                op_w       = 3,
  parameter int                addr_w     = 8,
  parameter int                depth      = 2,
  parameter logic [addr_w-1:0] reset_addr = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                mem_req,
  output logic [addr_w-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [w-1:0]        mem_data,
  output logic                ins_valid,
  input  logic                ins_ready,
  output logic [op_w-1:0]     op,
  output logic [w-op_w-1:0]   arg,
  output logic [addr_w-1:0]   ins_pc,
  input  logic                redirect,
  input  logic [addr_w-1:0]   redirect_addr,
  output logic                halted
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = $clog2(depth + 1);

  typedef enum logic [1:0] {FETCH, HALT, DRAIN} state_t;

  typedef struct packed {
    logic [op_w-1:0]   op;
    logic [w-op_w-1:0] arg;
    logic [addr_w-1:0] pc;
  } entry_t;

  state_t            state_q, state_n;
  logic [addr_w-1:0] pc_q, pc_n;
  logic              halted_n;
  logic              req_n;
  logic [addr_w-1:0] addr_n;
  logic [ptr_w-1:0]  wr_q, wr_n, rd_q, rd_n;
  logic [cnt_w-1:0]  count_q, count_n;
  entry_t            fifo_q [depth];
  entry_t            head;
  entry_t            incoming;

  logic push, pop;

  // Data is only kept when the request was genuinely ours, we are still
  // fetching, and no redirect is throwing the stream away this cycle.
  assign push     = mem_req & mem_ack & (state_q == FETCH) & ~redirect;
  assign pop      = ins_valid & ins_ready & ~redirect;
  assign incoming = '{op: mem_data[w-1 -: op_w], arg: mem_data[w-op_w-1:0], pc: mem_addr};

  // Decoder view is the FIFO head; every entry is a register.
  assign head      = fifo_q[rd_q];
  assign ins_valid = (count_q != '0);
  assign op        = head.op;
  assign arg       = head.arg;
  assign ins_pc    = head.pc;

  // Next-state, PC, FIFO bookkeeping and the next memory request.
  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    halted_n = halted;
    wr_n     = push ? wr_q + ptr_w'(1) : wr_q;
    rd_n     = pop  ? rd_q + ptr_w'(1) : rd_q;
    count_n  = count_q + cnt_w'(push) - cnt_w'(pop);
    req_n    = 1'b0;
    addr_n   = mem_addr;

    if (redirect) begin
      wr_n     = '0;
      rd_n     = '0;
      count_n  = '0;
      halted_n = 1'b0;
      pc_n     = redirect_addr;
      // An unacked request must still be completed (and dropped) first.
      state_n  = (mem_req && !mem_ack) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        FETCH: if (push) begin
          pc_n = pc_q + addr_w'(1);
          if (incoming.op == '0) begin
            state_n  = HALT;
            halted_n = 1'b1;
          end
        end
        DRAIN:   if (mem_ack) state_n = FETCH;
        HALT:    state_n = HALT;
        default: state_n = FETCH;
      endcase
    end

    // An outstanding request is held unchanged until it is acknowledged;
    // otherwise issue one only if its word is guaranteed a FIFO slot.
    if (mem_req && !mem_ack) begin
      req_n  = 1'b1;
      addr_n = mem_addr;
    end else begin
      req_n  = (state_n == FETCH) && (count_n < cnt_w'(depth));
      addr_n = pc_n;
    end
  end

  // Control state and memory request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      pc_q     <= reset_addr;
      halted   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= reset_addr;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      state_q  <= state_n;
      pc_q     <= pc_n;
      halted   <= halted_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
      wr_q     <= wr_n;
      rd_q     <= rd_n;
      count_q  <= count_n;
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage is reset because the head drives op/arg/ins_pc
      // directly and those must read zero out of reset; it is only a few flops.
      for (int i = 0; i < depth; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_q] <= incoming;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory responder
// pushes the expected {word, pc} into a scoreboard on every ack that should be
// kept, and the decoder side pops and compares on every handshake.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_req, mem_ack = 1'b0;
  logic [7:0] mem_addr, mem_data = '0;
  logic       ins_valid, ins_ready = 1'b0;
  logic [2:0] op;
  logic [4:0] arg;
  logic [7:0] ins_pc;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = '0;
  logic       halted;

  // Second instance with reset_addr = 0xFF for PC wrap-around.
  logic       mem_req2, ins_valid2, halted2;
  logic [7:0] mem_addr2, ins_pc2;
  logic [2:0] op2;
  logic [4:0] arg2;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .op(op), .arg(arg), .ins_pc(ins_pc),
    .redirect(redirect), .redirect_addr(redirect_addr), .halted(halted)
  );

  fetch_unit #(.reset_addr(8'hFF)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(1'b1), .mem_data(8'h25),
    .ins_valid(ins_valid2), .ins_ready(1'b1), .op(op2), .arg(arg2), .ins_pc(ins_pc2),
    .redirect(1'b0), .redirect_addr(8'h00), .halted(halted2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem_img [256];
  logic [15:0] sb [$];
  int          lat = 0;
  int          wait_cnt = 0;
  logic [7:0]  held_addr = '0;
  logic [7:0]  last_ack_addr = '0;
  int          n_acks = 0;
  int          n_pops = 0;
  bit          drop_next = 0;
  bit          acked = 0;

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem_img[i] = {3'((i % 7) + 1), 5'(i)};
  endtask

  task automatic do_reset(input int latency);
    reset_n = 1'b0;
    mem_ack = 1'b0;
    ins_ready = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    sb.delete();
    lat = latency;
    wait_cnt = 0;
    n_acks = 0;
    n_pops = 0;
    drop_next = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One cycle: at the negedge check the decoder handshake against the
  // scoreboard, answer the memory port, then advance to the next negedge.
  task automatic tick();
    logic [15:0] exp;
    acked = 0;
    if (ins_valid && ins_ready && !redirect) begin
      checks++;
      n_pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got op %h arg %h pc %h, required no instruction", op, arg, ins_pc);
      end else begin
        exp = sb.pop_front();
        if ({op, arg, ins_pc} !== exp) begin
          errors++;
          $display("FAIL sb_instr: got op %h arg %h pc %h, required op %h arg %h pc %h",
                   op, arg, ins_pc, exp[15:13], exp[12:8], exp[7:0]);
        end
      end
    end
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_cnt > 0) begin
        checks++;
        if (mem_addr !== held_addr) begin
          errors++;
          $display("FAIL addr_stable: got %h, required %h", mem_addr, held_addr);
        end
      end else begin
        held_addr = mem_addr;
      end
      if (wait_cnt >= lat) begin
        mem_ack = 1'b1;
        mem_data = mem_img[mem_addr];
        n_acks++;
        last_ack_addr = mem_addr;
        acked = 1;
        if (drop_next) drop_next = 0;
        else if (!redirect) sb.push_back({mem_img[mem_addr], mem_addr});
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset(5);
    checks++;
    if ({mem_req, mem_addr, ins_valid, op, arg, ins_pc, halted} !== '0) begin
      errors++;
      $display("FAIL reset_state: got req %b addr %h valid %b op %h arg %h pc %h halted %b, required all zero",
               mem_req, mem_addr, ins_valid, op, arg, ins_pc, halted);
    end
    tick(); tick();
    // Request is now pending; pull reset mid-cycle.
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, ins_valid, halted} !== '0) begin
      errors++;
      $display("FAIL reset_mid_req: got req %b addr %h valid %b halted %b, required all zero",
               mem_req, mem_addr, ins_valid, halted);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_halt();
    init_mem();
    mem_img[0] = 8'h25; mem_img[1] = 8'h46; mem_img[2] = 8'h00;
    do_reset(0);
    ins_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (n_pops !== 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL halt_pops: got %0d pops %0d left, required 3 pops 0 left", n_pops, sb.size());
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_flag: got %b, required 1", halted);
    end
    checks++;
    if (n_acks !== 3 || last_ack_addr !== 8'h02 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_noreq: got acks %0d last %h req %b, required 3 02 0", n_acks, last_ack_addr, mem_req);
    end
    init_mem();
  endtask

  task automatic test_backpressure();
    bit done = 0;
    do_reset(0);
    repeat (8) tick();
    checks++;
    if (n_acks !== 2 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL full_stop: got acks %0d req %b, required 2 0", n_acks, mem_req);
    end
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 8'h00) begin
      errors++;
      $display("FAIL full_head: got valid %b pc %h, required 1 00", ins_valid, ins_pc);
    end
    ins_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (n_acks >= 3) done = 1;
    end
    checks++;
    if (!done || last_ack_addr !== 8'h02) begin
      errors++;
      $display("FAIL resume_addr: got done %b addr %h, required 1 02", done, last_ack_addr);
    end
    repeat (4) tick();
  endtask

  task automatic test_late_ack();
    bit done = 0;
    bit v_before;
    do_reset(3);
    ins_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      v_before = ins_valid;
      tick();
      if (acked) begin
        done = 1;
        checks++;
        if (v_before !== 1'b0 || ins_valid !== 1'b1) begin
          errors++;
          $display("FAIL late_latency: got valid %b then %b, required 0 then 1", v_before, ins_valid);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL late_timeout: got no ack, required one ack");
    end
    repeat (10) tick();
  endtask

  task automatic test_redirect_drain();
    bit done = 0;
    do_reset(2);
    ins_ready = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_addr = 8'h40;
    tick();
    redirect = 1'b0;
    drop_next = 1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: got req %b addr %h valid %b, required 1 00 0", mem_req, mem_addr, ins_valid);
    end
    tick(); tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h40 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_next: got req %b addr %h valid %b, required 1 40 0", mem_req, mem_addr, ins_valid);
    end
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (n_pops >= 2) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pops, required 2", n_pops);
    end
  endtask

  task automatic test_redirect_flush();
    bit done = 0;
    do_reset(0);
    repeat (6) tick();
    checks++;
    if (ins_valid !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: got valid %b req %b, required 1 0", ins_valid, mem_req);
    end
    sb.delete();
    ins_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 8'h80;
    tick();
    redirect = 1'b0;
    checks++;
    if (ins_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h80) begin
      errors++;
      $display("FAIL flush_post: got valid %b req %b addr %h, required 0 1 80", ins_valid, mem_req, mem_addr);
    end
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (n_pops >= 3) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL flush_timeout: got %0d pops, required 3", n_pops);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset(0);
    checks++;
    if (mem_req2 !== 1'b0 || mem_addr2 !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_reset: got req %b addr %h, required 0 ff", mem_req2, mem_addr2);
    end
    @(negedge clock);
    checks++;
    if (mem_req2 !== 1'b1 || mem_addr2 !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_req: got req %b addr %h, required 1 ff", mem_req2, mem_addr2);
    end
    @(negedge clock);
    checks++;
    if (mem_addr2 !== 8'h00 || ins_valid2 !== 1'b1 || ins_pc2 !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_first: got addr %h valid %b pc %h, required 00 1 ff", mem_addr2, ins_valid2, ins_pc2);
    end
    @(negedge clock);
    checks++;
    if (ins_valid2 !== 1'b1 || ins_pc2 !== 8'h00 || op2 !== 3'd1 || arg2 !== 5'd5) begin
      errors++;
      $display("FAIL wrap_second: got valid %b pc %h op %h arg %h, required 1 00 1 05",
               ins_valid2, ins_pc2, op2, arg2);
    end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_basic_halt();
    test_backpressure();
    test_late_ack();
    test_redirect_drain();
    test_redirect_flush();
    test_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
